// File: rtl/imem_loader.sv
// imem_loader: encodes symbolic I-type ALU requests (ADDI/XORI/ORI/ANDI) into
// RV32I instruction words and writes them to consecutive instruction-memory
// addresses starting at 0.
//
// Build option: define IMEM_LOADER_READBACK_EN to read back and verify every
// written word (READ/CHECK states, err[1] on mismatch). When it is undefined,
// mem_rdata is ignored and err[1] is tied to 0.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clear           synchronous restart, same effect as rst
//   req_valid/ready request handshake (req_ready is combinational)
//   req_op/rd/rs1/imm/last  symbolic request payload
//   mem_we/addr/wdata       instruction-memory write port
//   mem_rdata       synchronous-read data (readback build only)
//   done            sticky program-loaded flag
//   err             sticky errors: [0] illegal op, [1] readback mismatch
//   count           number of words written
module imem_loader #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [11:0]       req_imm,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

`ifdef IMEM_LOADER_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;
    // After CHECK the count already includes the word just written.
    localparam logic [CNT_W-1:0] CAP = CNT_W'(2 ** ADDR_W);
`else
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DONE} state_t;
    // In WRITE the count has not yet been incremented for the current word.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** ADDR_W) - 1);
`endif

    state_t      state_q, state_d;
    logic        last_q;
    logic        err_ill_q;
    logic        err_rb;
    logic        accept_c;
    logic        legal_c;
    logic [2:0]  funct3_c;
    logic [31:0] enc_c;

    assign req_ready = (state_q == S_IDLE) && !clear && !rst;
    assign accept_c  = req_valid && req_ready;
    assign err       = {err_rb, err_ill_q};

    // Op-code to funct3 translation and instruction encoding.
    always_comb begin
        legal_c  = 1'b1;
        funct3_c = 3'b000;
        case (req_op)
            3'd1:    funct3_c = 3'b000;
            3'd2:    funct3_c = 3'b100;
            3'd3:    funct3_c = 3'b110;
            3'd4:    funct3_c = 3'b111;
            default: legal_c  = 1'b0;
        endcase
        enc_c = {req_imm, req_rs1, funct3_c, req_rd, OPCODE_OP_IMM};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (legal_c)       state_d = S_WRITE;
                    else if (req_last) state_d = S_DONE;
                    else               state_d = S_IDLE;
                end
            end
`ifdef IMEM_LOADER_READBACK_EN
            S_WRITE: state_d = S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = (last_q || count == CAP) ? S_DONE : S_IDLE;
`else
            S_WRITE: state_d = (last_q || count == LAST_CNT) ? S_DONE : S_IDLE;
`endif
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; rst and clear restart everything.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_q    <= 1'b0;
            done      <= 1'b0;
            err_ill_q <= 1'b0;
            count     <= '0;
        end else begin
            state_q <= state_d;
            mem_we  <= (state_d == S_WRITE);
            done    <= (state_d == S_DONE);
            if (accept_c) begin
                mem_wdata <= enc_c;
                // count doubles as the write pointer; it never reaches 2^ADDR_W here.
                mem_addr  <= count[ADDR_W-1:0];
                last_q    <= req_last;
                if (!legal_c) err_ill_q <= 1'b1;
            end
            if (state_q == S_WRITE) count <= count + CNT_W'(1);
        end
    end

`ifdef IMEM_LOADER_READBACK_EN
    logic err_rb_q;

    // Readback compare: mem_rdata carries the word addressed during WRITE/READ.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_rb_q <= 1'b0;
        end else if (state_q == S_CHECK && mem_rdata != mem_wdata) begin
            err_rb_q <= 1'b1;
        end
    end
    assign err_rb = err_rb_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign err_rb       = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader and encoder for the single-cycle CPU. It accepts symbolic I-type ALU requests (operation code, rd, rs1, imm12) over a valid/ready handshake and encodes each one into a 32-bit RV32I instruction word. It writes the words to consecutive instruction-memory addresses starting at 0. It is the writer-side counterpart of the instruction decoder: a decoder fed with any word this block emits recovers the same `alu_op`, `imm12` and `rf_we=1`.

## Interface
- `ADDR_W`, default 4: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous restart. Same effect as `rst`; `rst` has priority.
- `req_valid`  in  1: request valid.
- `req_ready`  out  1: block can accept a request.
- `req_op`  in  3: encoding 1=ADDI, 2=XORI, 3=ORI, 4=ANDI. Values 0 and 5-7 are illegal.
- `req_rd`  in  5: destination register.
- `req_rs1`  in  5: source register.
- `req_imm`  in  12: immediate field.
- `req_last`  in  1: this is the final instruction of the program.
- `mem_we`  out  1: instruction-memory write strobe.
- `mem_addr`  out  ADDR_W: word address.
- `mem_wdata`  out  32: encoded instruction word.
- `mem_rdata`  in  32: memory read data. Synchronous read; data is valid the cycle after the address is presented. Used only under the readback option.
- `done`  out  1: program loaded. Sticky.
- `err`  out  2: sticky error flags. [0] illegal op; [1] readback mismatch.
- `count`  out  ADDR_W+1: number of words written.

## Operation
- Encoding: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
- funct3 per op: ADDI 000, XORI 100, ORI 110, ANDI 111.
- FSM states: IDLE, WRITE, READ, CHECK, DONE.
- IDLE:
  - `req_ready = (state==IDLE) && !clear && !rst`.
  - On `req_valid && req_ready`: latch the encoded word into `mem_wdata`, the current write pointer into `mem_addr`, and `req_last`.
  - Legal op: go to WRITE.
  - Illegal op: set `err[0]`. Nothing is written and `count` is unchanged. Go to DONE if `req_last`, else stay in IDLE.
- WRITE:
  - `mem_we=1` for exactly one cycle.
  - `count` and the write pointer increment.
  - Next state is READ if readback is compiled in. Otherwise: DONE if latched last or `count` reaches 2^ADDR_W, else IDLE.
- READ: `mem_we=0`, `mem_addr` held. Memory performs the read.
- CHECK:
  - Compare `mem_rdata` with `mem_wdata`. On mismatch set `err[1]`; the word still counts.
  - Next state is DONE or IDLE, by the same rule as WRITE.
- DONE: `done=1`, `req_ready=0`. Exit only via `rst` or `clear`.
- Full memory: after the word at address 2^ADDR_W-1 is written, enter DONE even without `req_last`. `mem_addr` holds 2^ADDR_W-1. The write pointer never wraps.
- `clear`/`rst`, in any state including mid-WRITE:
  - Next cycle the block is in IDLE.
  - `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `count=0`, `done=0`, `err=0`.
  - A request presented in the same cycle as `clear` is not accepted.

## Timing
- Reset values: `req_ready` is 0 while `rst` is high, and 1 in the first cycle after release. `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `done=0`, `err=2'b00`, `count=0`.
- Handshake accepted at edge k:
  - `mem_we` is high during cycle k+1, with `mem_addr`/`mem_wdata` stable.
  - No readback: `req_ready` is high again in cycle k+2. Throughput is 1 word per 2 cycles.
  - Readback: READ in k+2, CHECK samples `mem_rdata` in k+3, `req_ready` in k+4.
- `done` rises in the cycle after the final WRITE (or CHECK); same for a final illegal request.
- `count` updates at the end of the WRITE cycle.
- The request bus is sampled only on the accepting edge. Changes at other times are ignored.

## Configuration
- `IMEM_LOADER_READBACK_EN` defined: READ and CHECK states exist, and every written word is verified against `mem_rdata`. A mismatch sets `err[1]`.
- Not defined: READ and CHECK are removed, `mem_rdata` is unused, and `err[1]` is tied to 0.

## Test plan
- ADDI, rd=1, rs1=2, imm=0x005 -> `mem_we` pulse at `mem_addr`=0, `mem_wdata`=0x00510093, `count`=1, `req_ready` high again at k+2 (no readback).
- ANDI, rd=3, rs1=3, imm=0xFFF, last=1 after one XORI -> second write at addr 1, data 0xFFF1F193. `done`=1 the following cycle, `count`=2, `req_ready` stays 0.
- `req_op`=5 -> no `mem_we`, `err`=2'b01, `count` unchanged. A following legal ORI rd=4, rs1=0, imm=0x0F0 writes 0x0F006213 at addr 0.
- ADDR_W=4, 16 legal requests without last -> 16 writes at addr 0..15, `done`=1 after the 16th, `count`=16. A 17th `req_valid` is never accepted.
- Readback build, bench memory flips bit 0 on the addr-2 read -> `err`=2'b10 after that CHECK. Other words match, and `count` still reaches 3.
- `clear` asserted in the WRITE cycle of the 2nd word, with `req_valid` held high -> the next cycle is IDLE with all outputs at reset values, and the request is not accepted that cycle. The next accepted request writes addr 0.
